instruction_fifo: RTL and testbench
===================================

# instruction_fifo

Parametrised first-word-fall-through instruction FIFO that sits between fetch and decode in the pipeline. It is the successor to the fixed two-entry instruction queue and generalises it in data width and depth. It adds a valid/ready handshake on both sides, an occupancy count, an almost-full flag and a synchronous flush for branch redirects. Storage is a circular buffer of `DEPTH` entries with wrap-bit read and write pointers.

## Interface
Parameters:
- `DATA_W`, default 32: instruction word width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `AFULL_THRESH`, default `DEPTH-1`: `almost_full` asserts when `count >= AFULL_THRESH`. Legal range is 1..`DEPTH`.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Reset is asynchronous and active-high.
- `flush`, in, 1: synchronous discard of all contents.
- `enq_valid`, in, 1: producer presents `enq_data`.
- `enq_data`, in, `DATA_W`: instruction to enqueue.
- `enq_ready`, out, 1: FIFO can accept an entry. Equals `~full`.
- `deq_valid`, out, 1: head entry is valid. Equals `~empty`.
- `deq_data`, out, `DATA_W`: head entry, driven combinationally from storage.
- `deq_ready`, in, 1: consumer takes the head.
- `count`, out, `$clog2(DEPTH+1)`: current occupancy.
- `full`, out, 1: high when `count == DEPTH`.
- `empty`, out, 1: high when `count == 0`.
- `almost_full`, out, 1: high when `count >= AFULL_THRESH`.

## Operation
- Enqueue fires when `enq_valid & enq_ready`. Dequeue fires when `deq_valid & deq_ready`.
- Enqueue: write `enq_data` to `mem[wr_ptr]`, then increment `wr_ptr`.
- Dequeue: increment `rd_ptr`.
- Pointers are `$clog2(DEPTH)+1` bits wide, with the MSB used as the wrap bit.
  - `empty` when the pointers are equal.
  - `full` when the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally modulo 2·`DEPTH`.
- `count` is held as a registered value, not derived from the pointers. It changes by +1 on enqueue only, −1 on dequeue only, and 0 when both fire or neither fires.
- There is no bypass path:
  - When the FIFO is empty, an enqueue is not visible on `deq_*` until the next cycle.
  - When the FIFO is full, `enq_ready` is 0 even if a dequeue fires in the same cycle.
  - There is no combinational path from `deq_ready` to `enq_ready`.
- Simultaneous enqueue and dequeue with 0 < `count` < `DEPTH`: both fire and `count` is unchanged.
- `flush` has priority over enqueue and dequeue in the same cycle. It sets `rd_ptr = wr_ptr = 0` and `count = 0`. Storage contents are left stale and are not observable because `deq_valid` is 0.
- Storage contents are never cleared except by reset.
- Handshake rules for the producer and consumer:
  - The producer holds `enq_data` stable while `enq_valid & ~enq_ready`.
  - The consumer may sample `deq_data` only while `deq_valid` is high.

## Timing
- Reset values (asserted immediately, asynchronously):
  - `count = 0`, `empty = 1`, `full = 0`, `almost_full = 0`.
  - `enq_ready = 1`, `deq_valid = 0`.
  - Pointers = 0, all storage = 0, so `deq_data = 0`.
- Reset asserted mid-operation discards all contents in the same way. The first enqueue is accepted on the first rising edge after `rst` deasserts.
- Enqueue-to-`deq_valid` latency is 1 cycle.
- All flags and `count` are registered or decoded from registers only; none depend on the current cycle's inputs.
- `flush` takes effect at the edge: the cycle after `flush` shows `empty = 1`. An `enq_valid` in the flush cycle is dropped.

## Structure
- Shared package `pipeline_pkg` holds `INSTR_W = 32` and `typedef logic [INSTR_W-1:0] instr_t`. The top-level instantiates `instruction_fifo #(.DATA_W(pipeline_pkg::INSTR_W))`.
- The FIFO itself is a single module. Pointer increment and full/empty decode go in the sub-module `fifo_ptr_ctrl`, parametrised by `DEPTH`, which outputs the pointers, `full` and `empty`.
- Parameter legality is checked at elaboration: `DEPTH` must be a power of two and at least 2, and `AFULL_THRESH` must be in range.

## Test plan
- Reset, then enqueue `0x11111111` → next cycle `deq_valid = 1`, `deq_data = 0x11111111`, `count = 1`.
- With `DEPTH = 4`, enqueue `0xA0`..`0xA3` with `deq_ready = 0` → `full = 1`, `enq_ready = 0`, `almost_full` is high from `count = 3`. A fifth enqueue is ignored. Draining then returns `0xA0, 0xA1, 0xA2, 0xA3` in order.
- With `count = 2`, assert `enq_valid` and `deq_ready` for 10 cycles with incrementing data → `count` stays 2, order is preserved, and both pointers wrap at least twice.
- Full FIFO with `deq_ready = 1` and `enq_valid = 1` → that cycle only the dequeue fires, `count` goes 4→3, and the enqueue is accepted the next cycle.
- With `count = 3`, assert `flush` together with `enq_valid` (data `0xDEAD`) → next cycle `empty = 1` and `count = 0`. `0xDEAD` never appears on `deq_data`.
- Assert `rst` asynchronously between edges with `count = 2` → outputs take their reset values immediately. After deassert, the first enqueue gives `count = 1`.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: instruction word width and instruction type.
package pipeline_pkg;
    localparam int INSTR_W = 32;
    typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit read/write pointers with full/empty decode for a power-of-two FIFO.
// Pointers advance one edge after the increment request; flush zeroes both.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_inc,
    input  logic                     rd_inc,
    output logic [$clog2(DEPTH):0]   wr_ptr,
    output logic [$clog2(DEPTH):0]   rd_ptr,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_inc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_inc) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Same index with opposite wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

// File: rtl/instruction_fifo.sv
// First-word-fall-through instruction FIFO between fetch and decode, 1-cycle enq-to-deq latency.
// No bypass: enq_ready = ~full from registers only, so a full FIFO refuses even while draining.
module instruction_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_W       = INSTR_W,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [DATA_W-1:0]          enq_data,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [DATA_W-1:0]          deq_data,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instruction_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("instruction_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              enq_fire;
    logic              deq_fire;

    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_inc (enq_fire),
        .rd_inc (deq_fire),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .full   (full),
        .empty  (empty)
    );

    // An enqueue in the flush cycle is dropped, so it must not touch storage either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq_fire && !flush) begin
            mem[wr_ptr[AW-1:0]] <= enq_data;
        end
    end

    assign deq_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign almost_full = (count >= CNT_W'(AFULL_THRESH));

    // The separately registered count must always agree with the pointer distance.
    ptr_count_consistent: assert property (
        @(posedge clk) disable iff (rst) CNT_W'(wr_ptr - rd_ptr) == count
    );
endmodule

// File: tb/tb_instruction_fifo.sv
// Scoreboard bench for instruction_fifo (DEPTH=4): directed stimulus, decoupled dequeue monitor.
module tb_instruction_fifo;
    import pipeline_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         enq_valid;
    instr_t       enq_data;
    logic         enq_ready;
    logic         deq_valid;
    instr_t       deq_data;
    logic         deq_ready;
    logic [2:0]   count;
    logic         full;
    logic         empty;
    logic         almost_full;

    int errors = 0;
    int checks = 0;
    instr_t exp_q[$];

    instruction_fifo #(.DATA_W(pipeline_pkg::INSTR_W), .DEPTH(4), .AFULL_THRESH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .deq_valid   (deq_valid),
        .deq_data    (deq_data),
        .deq_ready   (deq_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge; push data the bench expects to be accepted.
    task automatic cyc(input logic ev, input logic [31:0] ed, input logic dr,
                       input logic fl, input logic exp_acc);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        if (fl) exp_q.delete();
        if (exp_acc) exp_q.push_back(ed);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"},       32'(count), 32'd0);
        chk({tag, " empty"},       32'(empty), 32'd1);
        chk({tag, " full"},        32'(full), 32'd0);
        chk({tag, " almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, " enq_ready"},   32'(enq_ready), 32'd1);
        chk({tag, " deq_valid"},   32'(deq_valid), 32'd0);
        chk({tag, " deq_data"},    deq_data, 32'd0);
    endtask

    // Monitor: inputs change at the falling edge, so 2 time units later they are the
    // values the next rising edge will act on.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush && deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_unexpected: got 0x%0h, expected no dequeue", deq_data);
                end else begin
                    chk("deq_data_order", deq_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
        #3;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // First enqueue becomes visible one cycle later.
        cyc(1, 32'h1111_1111, 0, 0, 1);
        chk("first deq_valid", 32'(deq_valid), 32'd1);
        chk("first deq_data", deq_data, 32'h1111_1111);
        chk("first count", 32'(count), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("drained empty", 32'(empty), 32'd1);

        // Fill to full; almost_full from count 3.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'hA0 + 32'(i), 0, 0, 1);
            chk("fill count", 32'(count), 32'(i + 1));
            chk("fill almost_full", 32'(almost_full), (i >= 2) ? 32'd1 : 32'd0);
        end
        chk("full flag", 32'(full), 32'd1);
        chk("full enq_ready", 32'(enq_ready), 32'd0);
        cyc(1, 32'hA4, 0, 0, 0);
        chk("fifth ignored count", 32'(count), 32'd4);

        // Full with both sides active: only the dequeue fires.
        cyc(1, 32'hB0, 1, 0, 0);
        chk("full deq-only count", 32'(count), 32'd3);
        chk("full deq-only enq_ready", 32'(enq_ready), 32'd1);
        cyc(1, 32'hB0, 0, 0, 1);
        chk("retry accepted count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("drain count", 32'(count), 32'd0);

        // Steady-state streaming at count 2, pointers wrap repeatedly.
        cyc(1, 32'hC0, 0, 0, 1);
        cyc(1, 32'hC1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'hD0 + 32'(i), 1, 0, 1);
            chk("stream count", 32'(count), 32'd2);
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("stream drained", 32'(empty), 32'd1);

        // Flush with a concurrent enqueue of 0xDEAD.
        for (int i = 0; i < 3; i++) cyc(1, 32'hE0 + 32'(i), 0, 0, 1);
        chk("pre-flush count", 32'(count), 32'd3);
        cyc(1, 32'hDEAD, 0, 1, 0);
        chk("flush empty", 32'(empty), 32'd1);
        chk("flush count", 32'(count), 32'd0);
        cyc(0, 0, 1, 0, 0);
        chk("post-flush deq_valid", 32'(deq_valid), 32'd0);
        cyc(1, 32'hF0, 0, 0, 1);
        chk("post-flush data", deq_data, 32'hF0);
        cyc(0, 0, 1, 0, 0);

        // Asynchronous reset between edges with two entries held.
        cyc(1, 32'h60, 0, 0, 1);
        cyc(1, 32'h61, 0, 0, 0);
        exp_q.push_back(32'h61);
        cyc(0, 0, 0, 0, 0);
        chk("pre-reset count", 32'(count), 32'd2);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_vals("async reset");
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 32'h70, 0, 0, 1);
        chk("after reset count", 32'(count), 32'd1);
        chk("after reset data", deq_data, 32'h70);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
